// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/halt controller.
package pipeline_ctrl_pkg;

    localparam int unsigned REG_AW    = 3;
    localparam int unsigned FWD_W     = 2;
    localparam int unsigned BUBBLE_W  = 8;
    localparam int unsigned DRAIN_W   = 2;
    localparam int unsigned INC_W     = 2;

    localparam logic [FWD_W-1:0]    FWD_RF       = 2'b00;
    localparam logic [FWD_W-1:0]    FWD_WB       = 2'b01;
    localparam logic [FWD_W-1:0]    FWD_EX       = 2'b10;
    localparam logic [DRAIN_W-1:0]  DRAIN_CYCLES = 2'd2;
    localparam logic [BUBBLE_W-1:0] BUBBLE_MAX   = 8'hFF;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    // Saturating add of a small increment onto the bubble counter.
    function automatic logic [BUBBLE_W-1:0] bubble_add(
        input logic [BUBBLE_W-1:0] cnt,
        input logic [INC_W-1:0]    inc
    );
        logic [BUBBLE_W:0] sum;
        sum = (BUBBLE_W+1)'(cnt) + (BUBBLE_W+1)'(inc);
        return (sum > (BUBBLE_W+1)'(BUBBLE_MAX)) ? BUBBLE_MAX : sum[BUBBLE_W-1:0];
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Signal bundle between the pipeline datapath and its hazard/halt controller.
interface pipeline_ctrl_if;
    import pipeline_ctrl_pkg::*;

    logic [REG_AW-1:0]   rs1_IF_ID;
    logic [REG_AW-1:0]   rs2_IF_ID;
    logic [REG_AW-1:0]   rd_ID_EX;
    logic                regWrite_ID_EX;
    logic [REG_AW-1:0]   rd_EX_WB;
    logic                regWrite_EX_WB;
    logic                branch_EX_WB;
    logic                haltReq;
    logic                resume;
    logic                bubbleClr;
    logic                pcWrite;
    logic                pcSel;
    logic                ifidWrite;
    logic                ifidFlush;
    logic                idexFlush;
    logic [FWD_W-1:0]    fwdA;
    logic [FWD_W-1:0]    fwdB;
    logic                halted;
    logic [BUBBLE_W-1:0] bubbleCnt;

    modport master (
        output rs1_IF_ID, rs2_IF_ID, rd_ID_EX, regWrite_ID_EX, rd_EX_WB,
               regWrite_EX_WB, branch_EX_WB, haltReq, resume, bubbleClr,
        input  pcWrite, pcSel, ifidWrite, ifidFlush, idexFlush, fwdA, fwdB,
               halted, bubbleCnt
    );

    modport slave (
        input  rs1_IF_ID, rs2_IF_ID, rd_ID_EX, regWrite_ID_EX, rd_EX_WB,
               regWrite_EX_WB, branch_EX_WB, haltReq, resume, bubbleClr,
        output pcWrite, pcSel, ifidWrite, ifidFlush, idexFlush, fwdA, fwdB,
               halted, bubbleCnt
    );

endinterface

// File: rtl/forward_unit.sv
// Operand bypass select for one source register; youngest producer wins.
module forward_unit
    import pipeline_ctrl_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_ex,
    input  logic              reg_write_ex,
    input  logic [REG_AW-1:0] rd_wb,
    input  logic              reg_write_wb,
    output logic [FWD_W-1:0]  fwd_c
);

    // Every register is forwardable, including r0.
    always_comb begin
        fwd_c = FWD_RF;
        if (reg_write_ex && (rd_ex == rs)) begin
            fwd_c = FWD_EX;
        end else if (reg_write_wb && (rd_wb == rs)) begin
            fwd_c = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline controller: operand forwarding, branch squash, and drain-to-halt sequencing.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    pipeline_ctrl_if.slave bus
);

    state_t               state_q, state_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [BUBBLE_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic [INC_W-1:0]     bubble_inc;
    logic [FWD_W-1:0]     fwd_a_raw, fwd_b_raw;

    logic pc_write, pc_sel, ifid_write, ifid_flush, idex_flush, halted;

    forward_unit u_fwd_a (
        .rs           (bus.rs1_IF_ID),
        .rd_ex        (bus.rd_ID_EX),
        .reg_write_ex (bus.regWrite_ID_EX),
        .rd_wb        (bus.rd_EX_WB),
        .reg_write_wb (bus.regWrite_EX_WB),
        .fwd_c        (fwd_a_raw)
    );

    forward_unit u_fwd_b (
        .rs           (bus.rs2_IF_ID),
        .rd_ex        (bus.rd_ID_EX),
        .reg_write_ex (bus.regWrite_ID_EX),
        .rd_wb        (bus.rd_EX_WB),
        .reg_write_wb (bus.regWrite_EX_WB),
        .fwd_c        (fwd_b_raw)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            drain_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            drain_cnt_q  <= drain_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    // Next state and stage controls; a taken branch overrides drain bubbles.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        bubble_inc  = '0;
        pc_write    = 1'b0;
        pc_sel      = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        halted      = 1'b0;

        if (!rst) begin
            case (state_q)
                RUN: begin
                    pc_write   = 1'b1;
                    ifid_write = 1'b1;
                    if (bus.branch_EX_WB) begin
                        pc_sel     = 1'b1;
                        ifid_flush = 1'b1;
                        idex_flush = 1'b1;
                        bubble_inc = 2'd2;
                    end
                    if (bus.haltReq) begin
                        state_d     = DRAIN;
                        drain_cnt_d = DRAIN_CYCLES;
                    end
                end
                DRAIN: begin
                    ifid_write  = 1'b1;
                    ifid_flush  = 1'b1;
                    bubble_inc  = 2'd1;
                    drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                    if (bus.branch_EX_WB) begin
                        pc_write   = 1'b1;
                        pc_sel     = 1'b1;
                        idex_flush = 1'b1;
                        bubble_inc = 2'd2;
                    end
                    if (drain_cnt_q <= DRAIN_W'(1)) begin
                        state_d = HALTED;
                    end
                end
                HALTED: begin
                    halted = 1'b1;
                    if (bus.resume) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end

        bubble_cnt_d = bus.bubbleClr ? '0 : bubble_add(bubble_cnt_q, bubble_inc);
    end

    assign bus.pcWrite   = pc_write;
    assign bus.pcSel     = pc_sel;
    assign bus.ifidWrite = ifid_write;
    assign bus.ifidFlush = ifid_flush;
    assign bus.idexFlush = idex_flush;
    assign bus.halted    = halted;
    assign bus.fwdA      = rst ? FWD_RF : fwd_a_raw;
    assign bus.fwdB      = rst ? FWD_RF : fwd_b_raw;
    assign bus.bubbleCnt = bubble_cnt_q;

endmodule
